ifetch_fill_ctrl: RTL and testbench
===================================

# ifetch_fill_ctrl

Instruction-fetch miss handler sitting directly downstream of the program counter. It consumes the current PC and the instruction-cache hit signal, and on a miss fetches the whole cache block from multi-cycle instruction memory. Each returned word is written into the cache data array, followed by the tag. While the fill is in progress it holds the PC frozen through `stall`, which drives the PC's enable low.

## Interface
Parameters:
- BLOCK_WORDS, 8, 16-bit words per cache block; power of two, 2..16.
- WORD_IDX_W, 3, log2(BLOCK_WORDS); width of `fill_word`.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc  in  16  current byte address from the PC.
- fetch_valid  in  1  a fetch at `pc` is requested this cycle.
- hit  in  1  cache tag-compare result for `pc` (combinational from the cache).
- mem_rd  out  1  memory read request, one word per cycle.
- mem_addr  out  16  byte address of the current request.
- mem_data_valid  in  1  returned word valid; memory returns in request order, fixed latency.
- mem_data  in  16  returned word.
- fill_we  out  1  write `fill_data` into the data array at `fill_word`.
- fill_word  out  WORD_IDX_W  word index within the block.
- fill_data  out  16  equals `mem_data`.
- tag_we  out  1  write the tag/valid for the block at `pc`.
- stall  out  1  high freezes the PC (PC enable = ~stall).
- miss_count  out  16  miss counter (see Configuration).

## Operation
- States: IDLE, ISSUE, DRAIN. Registers: `base` (16), `req_cnt` and `ret_cnt` (WORD_IDX_W+1 bits each).
- IDLE:
  - `miss` = fetch_valid & ~hit.
  - On `miss`: latch `base` = pc with the low log2(BLOCK_WORDS*2) bits cleared; clear both counters; go to ISSUE.
- ISSUE:
  - mem_rd=1; mem_addr = base + (req_cnt<<1); req_cnt increments every cycle.
  - Go to DRAIN in the cycle the last request (req_cnt = BLOCK_WORDS-1) issues.
- DRAIN: mem_rd=0; only returns are accepted.
- Returns, in ISSUE and DRAIN:
  - On each mem_data_valid: fill_we=1, fill_word=ret_cnt[WORD_IDX_W-1:0], then ret_cnt increments.
  - When the last word returns (ret_cnt = BLOCK_WORDS-1): tag_we=1 in the same cycle, and the next state is IDLE.
  - This holds even if the state is still ISSUE, which can only happen with latency-0 memory.
- mem_data_valid in IDLE is ignored: no writes occur.
- stall = (IDLE & miss) | ISSUE | DRAIN. It is combinational, so the PC is frozen from the miss-detect cycle onward.
- fetch_valid, hit and pc are ignored outside IDLE.
- Outputs not listed as active are 0. mem_addr = 0 when mem_rd=0.

## Timing
- Reset: state=IDLE, counters=0, base=0, miss_count=0. All outputs 0 except `stall`, which follows `miss` combinationally in IDLE.
- Miss detected in cycle 0 (stall=1). Requests issue in cycles 1..BLOCK_WORDS.
- With memory latency L, returns occur in cycles 1+L..BLOCK_WORDS+L, and tag_we fires in cycle BLOCK_WORDS+L.
- The FSM is in IDLE at cycle BLOCK_WORDS+L+1. The refetch hits and stall drops that cycle.
- Miss penalty = BLOCK_WORDS+L+1 stalled cycles (13 for 8 words, L=4).
- Back-to-back misses: a new miss may be detected in the first IDLE cycle after a fill.
- rst mid-fill: returns to IDLE next edge; counters cleared; no further fill_we/tag_we; in-flight returns are ignored.

## Configuration
- IFETCH_MISS_CNT_EN defined:
  - miss_count increments by 1 on every IDLE→ISSUE transition.
  - It saturates at 16'hFFFF and clears on rst.
- Not defined: miss_count is constant 16'h0000 and no counter register is built.

## Test plan
- Reset then fetch_valid=1, hit=1, pc=16'h0040 -> stall=0, mem_rd never asserts, no fill_we/tag_we.
- Miss at pc=16'h0126, L=4 -> mem_addr 16'h0120..16'h012E in cycles 1..8; fill_we with fill_word 0..7 in cycles 5..12; tag_we only in cycle 12; stall=1 in cycles 0..12, stall=0 in cycle 13.
- Two consecutive misses (16'h0010, then 16'h0200 in first IDLE cycle) -> second fill base 16'h0200 starts immediately; with macro on, miss_count=2.
- rst asserted in cycle 6 of a fill -> IDLE next cycle, stall=0 (hit=1), later mem_data_valid pulses produce no fill_we/tag_we.
- mem_data_valid pulses while IDLE -> fill_we stays 0.
- Macro on, force miss_count to 16'hFFFF via 65535 misses or a preload hook, then one more miss -> remains 16'hFFFF; macro off -> miss_count 0 throughout.

Source files
------------

// File: rtl/ifetch_fill_ctrl.sv
// ifetch_fill_ctrl: I-cache miss handler; fetches a whole block from memory while stalling the PC.
// Optional miss counter enabled by defining IFETCH_MISS_CNT_EN.
module ifetch_fill_ctrl #(
    parameter int BLOCK_WORDS = 8,
    parameter int WORD_IDX_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           pc,
    input  logic                  fetch_valid,
    input  logic                  hit,
    output logic                  mem_rd,
    output logic [15:0]           mem_addr,
    input  logic                  mem_data_valid,
    input  logic [15:0]           mem_data,
    output logic                  fill_we,
    output logic [WORD_IDX_W-1:0] fill_word,
    output logic [15:0]           fill_data,
    output logic                  tag_we,
    output logic                  stall,
    output logic [15:0]           miss_count
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    localparam logic [WORD_IDX_W:0] LAST      = (WORD_IDX_W+1)'(BLOCK_WORDS - 1);
    localparam logic [WORD_IDX_W:0] CNT_ONE   = (WORD_IDX_W+1)'(1);
    localparam logic [15:0]         BASE_MASK = ~16'((2 * BLOCK_WORDS) - 1);
    state_t                state_q, state_d;
    logic [15:0]           base_q, base_d;
    logic [WORD_IDX_W:0]   req_cnt_q, req_cnt_d;
    logic [WORD_IDX_W:0]   ret_cnt_q, ret_cnt_d;
    logic                  miss;
    // state, block base and request/return counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            base_q    <= '0;
            req_cnt_q <= '0;
            ret_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            req_cnt_q <= req_cnt_d;
            ret_cnt_q <= ret_cnt_d;
        end
    end
    // next state, request issue and return write-back; the last return wins over ISSUE->DRAIN
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        req_cnt_d = req_cnt_q;
        ret_cnt_d = ret_cnt_q;
        mem_rd    = 1'b0;
        mem_addr  = 16'h0000;
        fill_we   = 1'b0;
        fill_word = '0;
        fill_data = 16'h0000;
        tag_we    = 1'b0;
        miss      = fetch_valid & ~hit;
        stall     = (state_q == IDLE) ? miss : 1'b1;
        if (state_q == IDLE && miss) begin
            base_d    = pc & BASE_MASK;
            req_cnt_d = '0;
            ret_cnt_d = '0;
            state_d   = ISSUE;
        end
        if (state_q == ISSUE) begin
            mem_rd    = 1'b1;
            mem_addr  = base_q + 16'({req_cnt_q, 1'b0});
            req_cnt_d = req_cnt_q + CNT_ONE;
            state_d   = (req_cnt_q == LAST) ? DRAIN : ISSUE;
        end
        if (state_q != IDLE && mem_data_valid) begin
            fill_we   = 1'b1;
            fill_word = ret_cnt_q[WORD_IDX_W-1:0];
            fill_data = mem_data;
            ret_cnt_d = ret_cnt_q + CNT_ONE;
            if (ret_cnt_q == LAST) begin
                tag_we  = 1'b1;
                state_d = IDLE;
            end
        end
    end
`ifdef IFETCH_MISS_CNT_EN
    logic [15:0] miss_cnt_q, miss_cnt_d;
    // saturating count of IDLE->ISSUE transitions
    always_comb begin
        miss_cnt_d = (state_q == IDLE && miss && miss_cnt_q != 16'hFFFF) ? miss_cnt_q + 16'd1 : miss_cnt_q;
    end
    // miss counter register
    always_ff @(posedge clk) begin
        if (rst) miss_cnt_q <= 16'h0000;
        else     miss_cnt_q <= miss_cnt_d;
    end
    assign miss_count = miss_cnt_q;
`else
    assign miss_count = 16'h0000;
`endif
endmodule

// File: tb/tb_ifetch_fill_ctrl.sv
// tb_ifetch_fill_ctrl: directed plus randomized checks against a cycle-offset reference model.
module tb_ifetch_fill_ctrl;
    localparam int N = 8;
    localparam int W = 3;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [15:0]  pc = 16'h0000;
    logic         fetch_valid = 1'b0;
    logic         hit = 1'b0;
    logic         mem_data_valid = 1'b0;
    logic [15:0]  mem_data = 16'h0000;
    logic         mem_rd, fill_we, tag_we, stall;
    logic [15:0]  mem_addr, fill_data, miss_count;
    logic [W-1:0] fill_word;
    int checks = 0;
    int passes = 0;
    int fails = 0;
    bit busy = 0;
    int k = 0;
    int lat = 0;
    int mc_m = 0;
    logic [15:0] base_m = 16'h0000;

    always #5 clk = ~clk;

    ifetch_fill_ctrl #(.BLOCK_WORDS(N), .WORD_IDX_W(W)) dut (
        .clk(clk), .rst(rst), .pc(pc), .fetch_valid(fetch_valid), .hit(hit),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data_valid(mem_data_valid),
        .mem_data(mem_data), .fill_we(fill_we), .fill_word(fill_word),
        .fill_data(fill_data), .tag_we(tag_we), .stall(stall), .miss_count(miss_count)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then advance the model.
    // While a fill is running the bench acts as the memory: word i returns L cycles after request i.
    task automatic tick(input logic r, input logic [15:0] p, input logic fv, input logic h,
                        input logic nv, input int l);
        logic miss;
        logic ret;
        logic [15:0] ea;
        logic [15:0] emc;
        rst = r;
        pc = p;
        fetch_valid = fv;
        hit = h;
        mem_data = 16'($urandom);
        ret = busy && (k >= lat + 1);
        mem_data_valid = busy ? ret : nv;
        #1;
        miss = !busy && fv && !h;
        ea = (busy && k <= N) ? 16'(base_m + 16'(2 * (k - 1))) : 16'h0000;
`ifdef IFETCH_MISS_CNT_EN
        emc = 16'(mc_m);
`else
        emc = 16'h0000;
`endif
        chk("stall", 16'(stall), 16'(busy || miss));
        chk("mem_rd", 16'(mem_rd), 16'(busy && k <= N));
        chk("mem_addr", mem_addr, ea);
        chk("fill_we", 16'(fill_we), 16'(ret));
        chk("fill_word", 16'(fill_word), ret ? 16'(k - lat - 1) : 16'h0000);
        if (ret) chk("fill_data", fill_data, mem_data);
        chk("tag_we", 16'(tag_we), 16'(ret && k == N + lat));
        chk("miss_count", miss_count, emc);
        if (r) begin
            busy = 0;
            mc_m = 0;
        end else if (busy) begin
            if (k == N + lat) busy = 0;
            else k++;
        end else if (miss) begin
            busy = 1;
            k = 1;
            lat = l;
            base_m = 16'(p - p % 16'(2 * N));
            mc_m = (mc_m < 65535) ? mc_m + 1 : mc_m;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        // reset state, and a miss while rst is held must not start a fill
        tick(1, 16'h0000, 0, 0, 0, 0);
        tick(1, 16'h0126, 1, 0, 1, 0);
        // hits never stall or request
        repeat (3) tick(0, 16'h0040, 1, 1, 0, 0);
        // stray returns while idle are ignored
        repeat (4) tick(0, 16'($urandom), 0, 0, 1, 0);
        // miss at 0x0126 with latency 4, then refetch hits in cycle 13
        tick(0, 16'h0126, 1, 0, 0, 4);
        repeat (N + 4) tick(0, 16'h0126, 1, 0, 0, 0);
        tick(0, 16'h0126, 1, 1, 0, 0);
        // back-to-back misses
        tick(0, 16'h0010, 1, 0, 0, 2);
        repeat (N + 2) tick(0, 16'h0010, 1, 0, 0, 0);
        tick(0, 16'h0200, 1, 0, 0, 3);
        repeat (N + 3) tick(0, 16'h0200, 1, 0, 0, 0);
        tick(0, 16'h0200, 1, 1, 0, 0);
        // rst in cycle 6 of a fill, then in-flight returns are ignored
        tick(0, 16'h0300, 1, 0, 0, 4);
        repeat (5) tick(0, 16'h0300, 1, 0, 0, 0);
        tick(1, 16'h0300, 1, 0, 0, 0);
        repeat (6) tick(0, 16'h0300, 1, 1, 1, 0);
        // latency-0 memory: last return coincides with last request
        tick(0, 16'h0ABC, 1, 0, 0, 0);
        repeat (N) tick(0, 16'h0ABC, 1, 0, 0, 0);
        tick(0, 16'h0ABC, 1, 1, 0, 0);
        // randomized traffic
        repeat (400) tick(0, 16'($urandom), 1'($urandom), ($urandom_range(0, 2) != 0), 1'($urandom),
                          int'($urandom_range(0, 6)));
        while (busy) tick(0, 16'h0000, 0, 0, 0, 0);
`ifdef IFETCH_MISS_CNT_EN
        // saturation: preload near the top, then two more misses
        force dut.miss_cnt_q = 16'hFFFE;
        #1;
        release dut.miss_cnt_q;
        mc_m = 65534;
        repeat (2) begin
            tick(0, 16'h0400, 1, 0, 0, 0);
            repeat (N) tick(0, 16'h0400, 1, 0, 0, 0);
        end
        tick(0, 16'h0400, 1, 1, 0, 0);
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
